// File: rtl/rdl_subreg_pkg.sv
// Shared types and helpers for the register-bus slice: APB adapter FSM
// states, timeout counter width and the byte-strobe to bit-mask expansion.
package rdl_subreg_pkg;

  // Width of the WAIT-state timeout counter; holds TimeoutCycles up to 255.
  localparam int ApbTimeoutW = 8;

  // APB adapter states; 2 bits leave one unused encoding, caught by default arms.
  typedef enum logic [1:0] {
    ApbIdle = 2'd0,
    ApbWait = 2'd1,
    ApbResp = 2'd2
  } apb_state_e;

  // Expand a 4-bit byte strobe into a 32-bit mask: bit i follows strb[i/8].
  function automatic logic [31:0] strb2mask(input logic [3:0] strb);
    logic [31:0] mask;
    mask = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      mask[i] = strb[i / 8];
    end
    return mask;
  endfunction

endpackage

// File: rtl/rdl_apb4_adapter.sv
// APB4 completer that converts each aligned APB transfer into a single-cycle
// register-bus request, waits for the register-side ack (bounded by a timeout)
// and returns the response as a one-cycle PREADY with PRDATA/PSLVERR.
// Misaligned addresses are answered with an error without touching the register bus.
module rdl_apb4_adapter
  import rdl_subreg_pkg::*;
#(
  parameter int AW            = 12,
  parameter int DW            = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [AW-1:0]   paddr,
  input  logic [DW-1:0]   pwdata,
  input  logic [DW/8-1:0] pstrb,
  output logic            pready,
  output logic [DW-1:0]   prdata,
  output logic            pslverr,
  output logic            reg_req,
  output logic            reg_we,
  output logic [AW-1:0]   reg_addr,
  output logic [DW-1:0]   reg_wdata,
  output logic [DW-1:0]   reg_wmask,
  input  logic            reg_ack,
  input  logic [DW-1:0]   reg_rdata,
  input  logic            reg_err
);

  if (DW != 32) begin : g_bad_dw
    $error("rdl_apb4_adapter: DW must be 32");
  end

  if ((TimeoutCycles < 1) || (TimeoutCycles > 255)) begin : g_bad_timeout
    $error("rdl_apb4_adapter: TimeoutCycles must be in 1..255");
  end

  localparam logic [ApbTimeoutW-1:0] TimeoutLim = ApbTimeoutW'(TimeoutCycles);

  apb_state_e             state;
  logic [ApbTimeoutW-1:0] wait_cnt;
  logic [ApbTimeoutW-1:0] wait_cnt_inc;

  // Next value of the WAIT counter, compared against the timeout limit.
  always_comb begin
    wait_cnt_inc = wait_cnt + 8'd1;
  end

  // Transfer FSM: request issue, ack/timeout wait and one-cycle response, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ApbIdle;
      wait_cnt  <= 8'd0;
      pready    <= 1'b0;
      prdata    <= {DW{1'b0}};
      pslverr   <= 1'b0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= {AW{1'b0}};
      reg_wdata <= {DW{1'b0}};
      reg_wmask <= {DW{1'b0}};
    end else begin
      // reg_req is a one-cycle pulse; only the IDLE accept path raises it.
      reg_req <= 1'b0;
      case (state)
        ApbIdle: begin
          pready   <= 1'b0;
          pslverr  <= 1'b0;
          prdata   <= {DW{1'b0}};
          wait_cnt <= 8'd0;
          if (psel && !penable) begin
            if (paddr[1:0] == 2'b00) begin
              reg_req   <= 1'b1;
              reg_we    <= pwrite;
              reg_addr  <= {paddr[AW-1:2], 2'b00};
              reg_wdata <= pwdata;
              reg_wmask <= pwrite ? strb2mask(pstrb) : {DW{1'b1}};
              state     <= ApbWait;
            end else begin
              // Misaligned: answer immediately with an error, register bus untouched.
              pready  <= 1'b1;
              pslverr <= 1'b1;
              prdata  <= {DW{1'b0}};
              state   <= ApbResp;
            end
          end else begin
            state <= ApbIdle;
          end
        end
        ApbWait: begin
          if (!psel) begin
            // Master abandoned the transfer; any later ack lands in IDLE and is ignored.
            wait_cnt <= 8'd0;
            state    <= ApbIdle;
          end else if (reg_ack) begin
            // Ack has priority over a coincident timeout.
            pready   <= 1'b1;
            pslverr  <= reg_err;
            prdata   <= reg_we ? {DW{1'b0}} : reg_rdata;
            wait_cnt <= 8'd0;
            state    <= ApbResp;
          end else if (wait_cnt_inc == TimeoutLim) begin
            pready   <= 1'b1;
            pslverr  <= 1'b1;
            prdata   <= {DW{1'b0}};
            wait_cnt <= 8'd0;
            state    <= ApbResp;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end
        ApbResp: begin
          pready   <= 1'b0;
          pslverr  <= 1'b0;
          prdata   <= {DW{1'b0}};
          wait_cnt <= 8'd0;
          state    <= ApbIdle;
        end
        default: begin
          pready   <= 1'b0;
          pslverr  <= 1'b0;
          prdata   <= {DW{1'b0}};
          wait_cnt <= 8'd0;
          state    <= ApbIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rdl_apb4_adapter.sv
// Directed, table-driven bench for rdl_apb4_adapter. Inputs change 1 ns after
// each rising edge; outputs are sampled at the same point.
module tb_rdl_apb4_adapter;

  logic        clk;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        reg_req, reg_we;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata, reg_wmask;
  logic        reg_ack, reg_err;
  logic [31:0] reg_rdata;

  int total = 0;
  int bad   = 0;

  rdl_apb4_adapter #(.AW(12), .DW(32), .TimeoutCycles(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wmask(reg_wmask),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ack_dly;     // cycles after the reg_req cycle; -1 = never
    logic [31:0] rdata;
    logic        err;
    logic        b2b;         // setup directly after previous RESP
    int          exp_req;
    logic [11:0] exp_addr;
    logic [31:0] exp_mask;
    int          exp_lat;     // cycles from setup to pready
    logic [31:0] exp_prdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; reg_ack = 1'b0; reg_rdata = 32'h0; reg_err = 1'b0;
  endtask

  // Count pready/reg_req cycles over n cycles with the bus idle.
  task automatic watch(input int n, output int n_pready, output int n_req);
    n_pready = 0; n_req = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      reg_ack = 1'b0;
      if (pready)  n_pready++;
      if (reg_req) n_req++;
    end
  endtask

  // Full APB transfer with a scripted register-side responder.
  task automatic run(input vec_t v, input string tag);
    int lat, nreq, c;
    logic r_we, outside_bad;
    logic [11:0] r_addr;
    logic [31:0] r_mask, r_wdata, g_prdata;
    logic g_err;
    @(posedge clk); #1;
    check({tag, "_pready_low_before"}, {31'h0, pready}, 32'h0);
    psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr;
    pwdata = v.wdata; pstrb = v.strb; reg_ack = 1'b0; reg_rdata = 32'h0; reg_err = 1'b0;
    lat = 0; nreq = 0; outside_bad = 1'b0;
    r_we = 1'b0; r_addr = 12'h0; r_mask = 32'h0; r_wdata = 32'h0; g_prdata = 32'h0; g_err = 1'b0;
    c = 1;
    while (c <= 40 && lat == 0) begin
      @(posedge clk); #1;
      penable = 1'b1;
      if (reg_req) begin
        nreq++;
        r_we = reg_we; r_addr = reg_addr; r_mask = reg_wmask; r_wdata = reg_wdata;
      end
      if (pready) begin
        lat = c; g_prdata = prdata; g_err = pslverr;
        reg_ack = 1'b0; reg_rdata = 32'h0; reg_err = 1'b0;
      end else begin
        if (pslverr || (prdata != 32'h0)) outside_bad = 1'b1;
        if (v.ack_dly >= 0 && c == 1 + v.ack_dly) begin
          reg_ack = 1'b1; reg_rdata = v.rdata; reg_err = v.err;
        end else begin
          reg_ack = 1'b0; reg_rdata = 32'h0; reg_err = 1'b0;
        end
      end
      c++;
    end
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_req_pulses"}, nreq, v.exp_req);
    check({tag, "_prdata"}, g_prdata, v.exp_prdata);
    check({tag, "_pslverr"}, {31'h0, g_err}, {31'h0, v.exp_err});
    check({tag, "_quiet_outside_resp"}, {31'h0, outside_bad}, 32'h0);
    if (v.exp_req > 0) begin
      check({tag, "_reg_we"}, {31'h0, r_we}, {31'h0, v.wr});
      check({tag, "_reg_addr"}, {20'h0, r_addr}, {20'h0, v.exp_addr});
      check({tag, "_reg_wmask"}, r_mask, v.exp_mask);
      if (v.wr) check({tag, "_reg_wdata"}, r_wdata, v.wdata);
    end
  endtask

  vec_t vecs[11];
  vec_t v;
  int np, nr;

  initial begin
    vecs[0]  = '{1'b1, 12'h010, 32'h12345678, 4'b0011,  0, 32'h0,        1'b0, 1'b0, 1, 12'h010, 32'h0000FFFF,  2, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 12'h020, 32'h0,        4'b0000,  3, 32'hDEADBEEF, 1'b0, 1'b0, 1, 12'h020, 32'hFFFFFFFF,  5, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 12'h024, 32'h0,        4'b1111, -1, 32'h0,        1'b0, 1'b0, 1, 12'h024, 32'hFFFFFFFF, 17, 32'h0,        1'b1};
    vecs[3]  = '{1'b1, 12'h013, 32'hCAFEF00D, 4'b1111, -1, 32'h0,        1'b0, 1'b0, 0, 12'h000, 32'h0,         1, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 12'h000, 32'h0,        4'b1111,  0, 32'hA5A50001, 1'b0, 1'b0, 1, 12'h000, 32'hFFFFFFFF,  2, 32'hA5A50001, 1'b0};
    vecs[5]  = '{1'b1, 12'h004, 32'h11223344, 4'b1010,  1, 32'hFFFF0000, 1'b1, 1'b1, 1, 12'h004, 32'hFF00FF00,  3, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 12'hFFC, 32'h55AA55AA, 4'b0000,  0, 32'h0,        1'b0, 1'b0, 1, 12'hFFC, 32'h00000000,  2, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 12'h7FF, 32'h0,        4'b1111, -1, 32'h0,        1'b0, 1'b0, 0, 12'h000, 32'h0,         1, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 12'h100, 32'h0,        4'b1111, 15, 32'h0BADF00D, 1'b0, 1'b0, 1, 12'h100, 32'hFFFFFFFF, 17, 32'h0BADF00D, 1'b0};
    vecs[9]  = '{1'b0, 12'h104, 32'h0,        4'b1111, 14, 32'h13579BDF, 1'b1, 1'b0, 1, 12'h104, 32'hFFFFFFFF, 16, 32'h13579BDF, 1'b1};
    vecs[10] = '{1'b1, 12'h00C, 32'h0F0F0F0F, 4'b0100,  0, 32'hFFFFFFFF, 1'b0, 1'b1, 1, 12'h00C, 32'h00FF0000,  2, 32'h0,        1'b0};

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 12'h0;
    pwdata = 32'h0; pstrb = 4'h0; reg_ack = 1'b0; reg_rdata = 32'h0; reg_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pready",  {31'h0, pready},  32'h0);
    check("reset_pslverr", {31'h0, pslverr}, 32'h0);
    check("reset_prdata",  prdata,           32'h0);
    check("reset_reg_req", {31'h0, reg_req}, 32'h0);
    check("reset_reg_bus", {reg_we, reg_addr, 19'h0} | reg_wdata | reg_wmask, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (!vecs[i].b2b) idle_cycle();
      run(vecs[i], $sformatf("vec%0d", i));
    end

    // Timeout, then a late ack in IDLE must not produce a response.
    idle_cycle();
    run(vecs[2], "late_ack_timeout");
    idle_cycle();
    reg_ack = 1'b1; reg_rdata = 32'h77777777; reg_err = 1'b0;
    watch(4, np, nr);
    check("late_ack_no_pready", np, 0);
    check("late_ack_no_req", nr, 0);

    // Reset asserted in the middle of WAIT.
    idle_cycle();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h030; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    check("rst_mid_req_seen", {31'h0, reg_req}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {29'h0, pready, pslverr, reg_req} | prdata | reg_wmask | reg_wdata, 32'h0);
    check("rst_mid_addr_we", {19'h0, reg_we, reg_addr}, 32'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    reg_ack = 1'b1; reg_rdata = 32'h12121212;
    watch(4, np, nr);
    check("rst_late_ack_no_pready", np, 0);
    v = '{1'b0, 12'h030, 32'h0, 4'hF, 0, 32'h3C3C3C3C, 1'b0, 1'b0, 1, 12'h030, 32'hFFFFFFFF, 2, 32'h3C3C3C3C, 1'b0};
    run(v, "after_reset");

    // psel dropped during WAIT: abandon, later ack ignored, next transfer normal.
    idle_cycle();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h040; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    reg_ack = 1'b1; reg_rdata = 32'h99999999;
    watch(4, np, nr);
    check("psel_drop_no_pready", np, 0);
    v = '{1'b1, 12'h044, 32'hFEDCBA98, 4'b1001, 2, 32'h0, 1'b0, 1'b0, 1, 12'h044, 32'hFF0000FF, 4, 32'h0, 1'b0};
    run(v, "after_psel_drop");

    idle_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rdl_apb4_adapter.md
Name: rdl_apb4_adapter

Overview:
- APB4 completer that turns bus transfers into single-cycle register-bus requests.
- Feeds the register address decoder; the decoder drives per-field we/wd into the subreg arbiters.
- Registers the request, waits for the register-side ack with a timeout, and returns PREADY/PRDATA/PSLVERR.
- All register-bus outputs are registered; one wait state minimum.

Parameters:
- AW, 12, APB/register address width in bits.
- DW, 32, data width; must be 32 (fixed at elaboration with $error otherwise).
- TimeoutCycles, 16, cycles in WAIT without ack before an error response; range 1..255.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- psel  input  1  APB select.
- penable  input  1  APB enable.
- pwrite  input  1  APB write.
- paddr  input  AW  APB byte address.
- pwdata  input  DW  APB write data.
- pstrb  input  DW/8  APB byte strobes.
- pready  output  1  APB ready.
- prdata  output  DW  APB read data.
- pslverr  output  1  APB error.
- reg_req  output  1  register-bus request pulse, one cycle.
- reg_we  output  1  write qualifier; valid while reg_req is high.
- reg_addr  output  AW  word-aligned address.
- reg_wdata  output  DW  write data.
- reg_wmask  output  DW  bit mask expanded from pstrb; all ones for reads.
- reg_ack  input  1  register-side completion; accepted in the request cycle or later.
- reg_rdata  input  DW  read data; valid with reg_ack.
- reg_err  input  1  decode error; valid with reg_ack.

Behaviour:
- Reset: every output is 0, state is IDLE, timeout counter is 0.
- States are IDLE, WAIT and RESP, held in a 2-bit enum.
- IDLE:
  - Setup phase (psel=1, penable=0) with paddr[1:0]==0: latch addr/wdata/mask/write; next cycle reg_req=1; go to WAIT.
  - Setup phase with paddr[1:0]!=0: no reg_req; go to RESP with err=1 and rdata=0.
- WAIT:
  - reg_req is high only on the first WAIT cycle.
  - reg_ack=1, including in the reg_req cycle: capture reg_rdata (reads only; 0 for writes) and reg_err; go to RESP.
  - Counter increments each WAIT cycle without ack. On reaching TimeoutCycles: go to RESP with err=1, rdata=0.
- RESP:
  - pready=1, prdata=captured data, pslverr=captured err, for exactly one cycle.
  - Return to IDLE, clear the counter.
  - A new setup phase in the following cycle is accepted, giving back-to-back transfers.
- Outside RESP: pready=0, pslverr=0, prdata=0.
- Latency: setup at cycle T, reg_req at T+1; with ack at T+1, pready at T+2.
- psel drops while in WAIT or RESP (protocol violation): return to IDLE next cycle, no pready. A late reg_ack is ignored.
- reg_ack in IDLE or RESP: ignored.
- Timeout and ack in the same cycle: ack wins and its data/err are used.
- Reset asserted mid-transfer: immediate return to reset values; the transfer is abandoned with no pready.
- reg_wmask bit i = pstrb[i/8] for writes. A write with pstrb=0 is still issued with mask 0.
- reg_addr = {paddr[AW-1:2], 2'b00}.

Decomposition:
- rdl_subreg_pkg gains:
  - apb_state_e {ApbIdle, ApbWait, ApbResp}.
  - Function strb2mask(strb) returning the byte-expanded mask.
  - Constant ApbTimeoutW = 8.
- No sub-module. The timeout counter and strobe expansion stay inline; total 150-250 lines.

Test Plan:
- Write 0x12345678 to 0x010, pstrb=4'b0011, ack in the req cycle:
  - reg_req one cycle with reg_we=1, reg_addr=0x010, reg_wmask=0x0000FFFF.
  - pready at T+2, pslverr=0.
- Read 0x020, ack 3 cycles after reg_req with rdata=0xDEADBEEF:
  - prdata=0xDEADBEEF with pready one cycle after ack.
  - reg_wmask=0xFFFFFFFF.
- Read 0x024, never acked, TimeoutCycles=16:
  - pready=1, pslverr=1, prdata=0 after 16 WAIT cycles.
  - A later ack is ignored and does not raise pready.
- Write to 0x013:
  - no reg_req.
  - pready at T+1 with pslverr=1.
- Back-to-back read 0x000 then write 0x004 with reg_err=1 on the second:
  - two reg_req pulses; first pslverr=0, second pslverr=1.
- rst_n low during WAIT, then release:
  - all outputs 0.
  - The ack arriving after release is ignored; the next transfer completes normally.
